// File: rtl/vga_fb_scheduler.sv
// Write-port scheduler for a triple-buffered 1-bpp VGA framebuffer: CPU stores, background clear, role rotation.
// Define VGA_FB_VSYNC_SWAP_EN to hold buffer rotation until the frame_start (vblank) pulse.
module vga_fb_scheduler #(
    parameter int          XW        = 10,
    parameter int          YW        = 10,
    parameter int          CLR_LINES = 600,
    parameter logic [23:0] SWAP_ADDR = 24'hFFFFFC,
    parameter int          FAIR_N    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_valid,
    input  logic               cpu_we,
    input  logic [23:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_ready,
    input  logic               frame_start,
    output logic [2:0]         fb_we,
    output logic [XW+YW-1:0]   fb_waddr,
    output logic               fb_wdata,
    output logic [2:0]         disp_sel,
    output logic               clr_busy
);

    localparam int AW = XW + YW;
    localparam int FW = $clog2(FAIR_N + 1);
    localparam logic [AW-1:0] CLR_LAST = AW'(CLR_LINES * (1 << XW) - 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_N);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t          state;
    logic [AW-1:0]   clr_ptr;
    logic [FW-1:0]   fair_cnt;
    logic [2:0]      disp;
    logic [2:0]      draw;
    logic [2:0]      clean;

    logic            cpu_pix;
    logic            cpu_swap;
    logic            force_clr;
    logic            rotate;
    logic            pix_win;
    logic            clr_win;

    assign cpu_pix   = cpu_valid & cpu_we & (cpu_addr[23:20] == 4'h0);
    assign cpu_swap  = cpu_valid & cpu_we & (cpu_addr == SWAP_ADDR);
    assign force_clr = (state == S_CLEAR) && (fair_cnt == FAIR_MAX);

`ifdef VGA_FB_VSYNC_SWAP_EN
    assign rotate = (state == S_IDLE) & cpu_swap & frame_start;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign rotate = (state == S_IDLE) & cpu_swap;
`endif

    // The whole bus stalls on a forced clear slot; swaps are accepted only when they rotate.
    always_comb begin
        cpu_ready = 1'b1;
        if (cpu_swap)
            cpu_ready = rotate;
        else if (force_clr)
            cpu_ready = 1'b0;
    end

    assign pix_win  = cpu_pix & ~force_clr;
    assign clr_win  = (state == S_CLEAR) & ~pix_win;
    assign disp_sel = disp;
    assign clr_busy = (state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CLEAR;
            clr_ptr  <= '0;
            fair_cnt <= '0;
            disp     <= 3'b001;
            draw     <= 3'b010;
            clean    <= 3'b100;
            fb_we    <= 3'b000;
            fb_waddr <= '0;
            fb_wdata <= 1'b0;
        end else begin
            fb_we <= 3'b000;
            if (pix_win) begin
                fb_we    <= draw;
                fb_waddr <= cpu_addr[AW-1:0];
                fb_wdata <= |cpu_wdata;
                if (state == S_CLEAR)
                    fair_cnt <= fair_cnt + 1'b1;
            end else if (clr_win) begin
                fb_we    <= clean;
                fb_waddr <= clr_ptr;
                fb_wdata <= 1'b0;
                clr_ptr  <= clr_ptr + 1'b1;
                fair_cnt <= '0;
                if (clr_ptr == CLR_LAST)
                    state <= S_IDLE;
            end
            // Rotation only happens in IDLE with the swap on the bus, so no write competes.
            if (rotate) begin
                disp     <= draw;
                draw     <= clean;
                clean    <= disp;
                clr_ptr  <= '0;
                fair_cnt <= '0;
                state    <= S_CLEAR;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        $onehot(disp) && $onehot(draw) && $onehot(clean) &&
        ((disp | draw | clean) == 3'b111) && ((fb_we & disp) == 3'b000));

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Scoreboard bench for vga_fb_scheduler with a small framebuffer geometry and randomized CPU traffic.
module tb_vga_fb_scheduler;

    localparam int          XW        = 4;
    localparam int          YW        = 4;
    localparam int          AW        = XW + YW;
    localparam int          CLR_LINES = 4;
    localparam int          FAIR_N    = 8;
    localparam int          TOTAL     = CLR_LINES << XW;
    localparam logic [23:0] SWAP_ADDR = 24'hFFFFFC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [23:0]   cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          frame_start = 1'b0;
    logic          cpu_ready;
    logic [2:0]    fb_we;
    logic [AW-1:0] fb_waddr;
    logic          fb_wdata;
    logic [2:0]    disp_sel;
    logic          clr_busy;

    vga_fb_scheduler #(
        .XW(XW), .YW(YW), .CLR_LINES(CLR_LINES), .SWAP_ADDR(SWAP_ADDR), .FAIR_N(FAIR_N)
    ) dut (
        .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .frame_start(frame_start), .fb_we(fb_we), .fb_waddr(fb_waddr),
        .fb_wdata(fb_wdata), .disp_sel(disp_sel), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    we;
        logic [AW-1:0] addr;
        logic          data;
        logic [2:0]    disp;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: which physical buffer holds each role, clear progress, fairness run length.
    int role_disp = 0, role_draw = 1, role_clean = 2;
    int m_cnt = 0, m_fair = 0;
    bit m_idle = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    function automatic logic vs_ok(input logic fs);
`ifdef VGA_FB_VSYNC_SWAP_EN
        return fs;
`else
        return fs | 1'b1;
`endif
    endfunction

    function automatic logic exp_ready(input logic v, input logic w, input logic [23:0] a, input logic fs);
        if (v && w && a == SWAP_ADDR) return m_idle && vs_ok(fs);
        if (!m_idle && m_fair == FAIR_N) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic rst, input logic v, input logic w,
                              input logic [23:0] a, input logic [31:0] d, input logic fs);
        exp_t e;
        logic pix, swp, forced;
        int   t;
        e = '0;
        if (rst) begin
            role_disp = 0; role_draw = 1; role_clean = 2;
            m_cnt = 0; m_fair = 0; m_idle = 1'b0;
        end else begin
            pix    = v && w && a[23:20] == 4'h0;
            swp    = v && w && a == SWAP_ADDR;
            forced = !m_idle && m_fair == FAIR_N;
            if (pix && !forced) begin
                e.we   = 3'(1 << role_draw);
                e.addr = a[AW-1:0];
                e.data = |d;
                if (!m_idle) m_fair++;
            end else if (!m_idle) begin
                e.we   = 3'(1 << role_clean);
                e.addr = AW'(m_cnt);
                e.data = 1'b0;
                m_cnt++;
                m_fair = 0;
                if (m_cnt == TOTAL) m_idle = 1'b1;
            end else if (swp && vs_ok(fs)) begin
                t = role_disp;
                role_disp = role_draw; role_draw = role_clean; role_clean = t;
                m_cnt = 0; m_fair = 0; m_idle = 1'b0;
            end
        end
        e.disp = 3'(1 << role_disp);
        e.busy = !m_idle;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic v, input logic w, input logic [23:0] a,
                        input logic [31:0] d, input logic fs, output logic rdy);
        @(negedge clk);
        reset = rst; cpu_valid = v; cpu_we = w; cpu_addr = a; cpu_wdata = d; frame_start = fs;
        #1;
        rdy = exp_ready(v, w, a, fs);
        if (!rst) chk("cpu_ready", 32'(cpu_ready), 32'(rdy));
        model_step(rst, v, w, a, d, fs);
    endtask

    // Monitor: each negedge shows the outputs registered at the preceding posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fb_we", 32'(fb_we), 32'(e.we));
                if (e.we != 3'b000) begin
                    chk("fb_waddr", 32'(fb_waddr), 32'(e.addr));
                    chk("fb_wdata", 32'(fb_wdata), 32'(e.data));
                end
                chk("disp_sel", 32'(disp_sel), 32'(e.disp));
                chk("clr_busy", 32'(clr_busy), 32'(e.busy));
            end
        end
    end

    initial begin
        logic        rdy;
        logic        swap_pend;
        logic        burst;
        logic        fs;
        logic [23:0] a;
        logic [31:0] d;
        int          r;
        swap_pend = 1'b0;
        burst     = 1'b0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, rdy);
        repeat (TOTAL + 8) step(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0, rdy);

        step(1'b0, 1'b1, 1'b1, 24'h00A005, 32'h5, 1'b0, rdy);
        step(1'b0, 1'b1, 1'b1, 24'h00A005, 32'h0, 1'b0, rdy);
        step(1'b0, 1'b1, 1'b0, 24'h00A005, 32'h1, 1'b0, rdy);
        step(1'b0, 1'b1, 1'b1, 24'h300000, 32'h1, 1'b0, rdy);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) burst = ($urandom_range(0, 2) == 0);
            fs = ($urandom_range(0, 15) == 0);
            d  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0;
            if (cyc == 1500 || cyc == 1501) begin
                swap_pend = 1'b0;
                step(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, fs, rdy);
            end else if (swap_pend) begin
                step(1'b0, 1'b1, 1'b1, SWAP_ADDR, d, fs, rdy);
                if (rdy) swap_pend = 1'b0;
            end else begin
                r = burst ? 0 : int'($urandom_range(0, 99));
                a = {4'h0, 20'($urandom)};
                if (r < 50) begin
                    step(1'b0, 1'b1, 1'b1, a, d, fs, rdy);
                end else if (r < 58) begin
                    step(1'b0, 1'b1, 1'b1, SWAP_ADDR, d, fs, rdy);
                    swap_pend = !rdy;
                end else if (r < 66) begin
                    step(1'b0, 1'b1, 1'b0, ($urandom_range(0, 1) == 1) ? a : SWAP_ADDR, d, fs, rdy);
                end else if (r < 74) begin
                    step(1'b0, 1'b1, 1'b1, {4'($urandom_range(1, 14)), 20'($urandom)}, d, fs, rdy);
                end else begin
                    step(1'b0, 1'b0, 1'b1, a, d, fs, rdy);
                end
            end
        end

        @(negedge clk);
        #2;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
